// File: rtl/heat_pkg.sv
// heat_pkg: shared state type and temperature constants for the heat sensing front end.
package heat_pkg;
    typedef enum logic [1:0] {WARMUP, IDLE, HEAT, COOL} state_t;
    localparam int TEMP_UNIT     = 16;
    localparam int DEF_TARGET    = 18 * TEMP_UNIT;
    localparam int DEF_THRESHOLD = 2 * TEMP_UNIT;
endpackage

// File: rtl/heat_avg4.sv
// heat_avg4: 4-entry sample window with running sum, saturating fill count and floor average.
module heat_avg4 #(
    parameter int WIDTH = 12
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    sample_valid,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] sample,
    output logic signed [WIDTH-1:0] avg,
    output logic                    full
);
    logic [3:0][WIDTH-1:0] win_q, win_d;
    logic signed [WIDTH+1:0] sum_q, sum_d;
    logic [2:0] fill_q, fill_d;

    // The sum always tracks the window contents, so clearing only the fill count keeps it consistent.
    always_comb begin
        win_d  = sample_valid ? {win_q[2:0], sample} : win_q;
        sum_d  = sample_valid ? sum_q + {{2{sample[WIDTH-1]}}, sample} - {{2{win_q[3][WIDTH-1]}}, win_q[3]} : sum_q;
        fill_d = clear ? 3'd0 : (sample_valid && fill_q != 3'd4) ? fill_q + 3'd1 : fill_q;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            win_q  <= '0;
            sum_q  <= '0;
            fill_q <= '0;
        end else begin
            win_q  <= win_d;
            sum_q  <= sum_d;
            fill_q <= fill_d;
        end
    end

    assign avg  = sum_q[WIDTH+1:2];
    assign full = fill_q == 3'd4;
endmodule

// File: rtl/heat_sense_conditioner.sv
// heat_sense_conditioner: turns averaged temperature samples into debounced heat/cool
// requests with hysteresis exit and stale-sensor fault handling.
module heat_sense_conditioner
    import heat_pkg::*;
#(
    parameter int WIDTH        = 12,
    parameter int DEBOUNCE     = 3,
    parameter int STALE_CYCLES = 1000
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    sample_valid,
    input  logic signed [WIDTH-1:0] sample,
    input  logic signed [WIDTH-1:0] target,
    input  logic        [WIDTH-1:0] threshold,
    output logic                    A,
    output logic                    B,
    output logic                    fault,
    output logic signed [WIDTH-1:0] avg
);
    localparam int CW = $clog2(STALE_CYCLES + 1);
    localparam int SW = $clog2(DEBOUNCE + 1);

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] cold_q, cold_d, hot_q, hot_d;
    logic fault_q, fault_d, a_q, b_q, pend_q, full, stale, eval, cold, hot;
    logic signed [WIDTH+1:0] avg_x, tgt_x, thr_x;

    heat_avg4 #(.WIDTH(WIDTH)) u_avg (
        .clock        (clock),
        .rst          (rst),
        .sample_valid (sample_valid),
        .clear        (stale),
        .sample       (sample),
        .avg          (avg),
        .full         (full)
    );

    assign avg_x = {{2{avg[WIDTH-1]}}, avg};
    assign tgt_x = {{2{target[WIDTH-1]}}, target};
    assign thr_x = {2'b00, threshold};
    assign cold  = avg_x < tgt_x - thr_x;
    assign hot   = avg_x > tgt_x + thr_x;
    assign stale = !sample_valid && cnt_q == CW'(STALE_CYCLES - 1);
    assign eval  = pend_q && full;

    // The evaluation of the window-filling capture already counts toward the debounce streak.
    always_comb begin
        state_d = state_q;
        cold_d  = cold_q;
        hot_d   = hot_q;
        fault_d = sample_valid ? 1'b0 : fault_q;
        cnt_d   = sample_valid ? '0 : stale ? cnt_q : cnt_q + CW'(1);
        if (stale) begin
            fault_d = 1'b1;
            state_d = WARMUP;
            cold_d  = '0;
            hot_d   = '0;
        end else if (eval) begin
            case (state_q)
                WARMUP, IDLE: begin
                    cold_d  = cold ? cold_q + SW'(1) : '0;
                    hot_d   = hot ? hot_q + SW'(1) : '0;
                    state_d = IDLE;
                    if (cold_d == SW'(DEBOUNCE)) begin
                        state_d = HEAT;
                        cold_d  = '0;
                    end else if (hot_d == SW'(DEBOUNCE)) begin
                        state_d = COOL;
                        hot_d   = '0;
                    end
                end
                HEAT:    state_d = avg_x >= tgt_x ? IDLE : HEAT;
                COOL:    state_d = avg_x <= tgt_x ? IDLE : COOL;
                default: state_d = WARMUP;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= WARMUP;
            cnt_q   <= '0;
            cold_q  <= '0;
            hot_q   <= '0;
            fault_q <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cold_q  <= cold_d;
            hot_q   <= hot_d;
            fault_q <= fault_d;
            a_q     <= state_d == HEAT;
            b_q     <= state_d == COOL;
            pend_q  <= sample_valid;
        end
    end

    assign A     = a_q;
    assign B     = b_q;
    assign fault = fault_q;
endmodule

// File: tb/tb_heat_sense_conditioner.sv
// tb_heat_sense_conditioner: directed checks of averaging, debounce, hysteresis, stale fault and async reset.
module tb_heat_sense_conditioner;
    import heat_pkg::*;

    logic clock = 1'b0;
    logic rst, sample_valid;
    logic signed [11:0] sample, target;
    logic [11:0] threshold;
    logic A, B, fault;
    logic signed [11:0] avg;
    int errors = 0;
    int checks = 0;

    heat_sense_conditioner #(.WIDTH(12), .DEBOUNCE(3), .STALE_CYCLES(20)) dut (
        .clock        (clock),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .target       (target),
        .threshold    (threshold),
        .A            (A),
        .B            (B),
        .fault        (fault),
        .avg          (avg)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Capture on the next rising edge, then let the evaluation edge pass; returns at a falling edge.
    task automatic smp(input int x);
        sample_valid = 1'b1;
        sample = 12'(x);
        @(negedge clock);
        sample_valid = 1'b0;
        @(negedge clock);
        chk("a_b_exclusive", int'(A & B), 0);
    endtask

    initial begin
        rst = 1'b0;
        sample_valid = 1'b0;
        sample = '0;
        target = 12'(DEF_TARGET);
        threshold = 12'(DEF_THRESHOLD);
        repeat (2) @(negedge clock);
        chk("reset_a", int'(A), 0);
        chk("reset_b", int'(B), 0);
        chk("reset_fault", int'(fault), 0);
        chk("reset_avg", int'(avg), 0);
        rst = 1'b1;
        @(negedge clock);
        repeat (3) smp(26 * TEMP_UNIT);
        chk("warmup_a", int'(A), 0);
        chk("warmup_b", int'(B), 0);
        chk("warmup_avg", int'(avg), 312);
        smp(416);
        chk("hot4_avg", int'(avg), 416);
        chk("hot4_b", int'(B), 0);
        smp(416);
        chk("hot5_b", int'(B), 0);
        smp(416);
        chk("hot6_b", int'(B), 1);
        chk("hot6_a", int'(A), 0);
        smp(72);
        chk("cool330_avg", int'(avg), 330);
        chk("cool330_b", int'(B), 1);
        smp(296);
        chk("cool300_b", int'(B), 1);
        smp(372);
        chk("cool289_avg", int'(avg), 289);
        chk("cool289_b", int'(B), 1);
        smp(412);
        chk("cool288_avg", int'(avg), 288);
        chk("cool288_b", int'(B), 0);
        chk("cool288_a", int'(A), 0);
        smp(-80);
        chk("glitch250a_avg", int'(avg), 250);
        chk("glitch250a_a", int'(A), 0);
        smp(296);
        chk("glitch250b_a", int'(A), 0);
        smp(452);
        chk("glitch270_avg", int'(avg), 270);
        chk("glitch270_a", int'(A), 0);
        smp(332);
        chk("cold1_a", int'(A), 0);
        smp(-80);
        chk("cold2_a", int'(A), 0);
        smp(296);
        chk("cold3_avg", int'(avg), 250);
        chk("cold3_a", int'(A), 1);
        chk("cold3_b", int'(B), 0);
        repeat (18) @(negedge clock);
        chk("stale19_fault", int'(fault), 0);
        chk("stale19_a", int'(A), 1);
        @(negedge clock);
        chk("stale20_fault", int'(fault), 1);
        chk("stale20_a", int'(A), 0);
        smp(100);
        chk("refill1_fault", int'(fault), 0);
        chk("refill1_a", int'(A), 0);
        smp(100);
        smp(100);
        smp(100);
        chk("refill4_avg", int'(avg), 100);
        chk("refill4_a", int'(A), 0);
        smp(100);
        chk("refill5_a", int'(A), 0);
        smp(100);
        chk("refill6_a", int'(A), 1);
        repeat (18) @(negedge clock);
        smp(100);
        chk("expire_tie_fault", int'(fault), 0);
        chk("expire_tie_a", int'(A), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_a", int'(A), 0);
        chk("async_avg", int'(avg), 0);
        chk("async_fault", int'(fault), 0);
        @(negedge clock);
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        repeat (3) smp(416);
        chk("rewarm_a", int'(A), 0);
        chk("rewarm_b", int'(B), 0);
        chk("rewarm_avg", int'(avg), 312);
        repeat (3) smp(416);
        chk("rehot_b", int'(B), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
